// File: rtl/rf_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rf_write_arbiter_pkg
//  Purpose  : Shared constants and types for the register-file write arbiter
//             (default widths, register count, $zero index, requester ids).
//  Revision : 1.0 - initial release
// ============================================================================
package rf_write_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_REGS   = 32;
    localparam int REG_ZERO   = 0;

    typedef enum logic [0:0] {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_t;

endpackage
`default_nettype wire

// File: rtl/rf_wr_slot.sv
`default_nettype none
// ============================================================================
//  Module   : rf_wr_slot
//  Purpose  : One-entry writeback holding buffer with valid/ready handshake.
//             Writes to the $zero register are accepted but dropped.
//  Ports    : clk, rst_n        - clock, async active-low reset
//             i_valid/o_ready   - requester handshake (ready = buffer empty)
//             i_waddr/i_wdata   - incoming write
//             i_clear           - entry granted by the arbiter this cycle
//             o_valid/o_waddr/o_wdata - buffered entry
//             o_load            - entry captured at the coming edge
//             o_nxt_valid/o_nxt_waddr - buffer contents after the coming edge
//  Revision : 1.0 - initial release
// ============================================================================
module rf_wr_slot
    import rf_write_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_clear,
    output logic              o_ready,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_load,
    output logic              o_nxt_valid,
    output logic [ADDR_W-1:0] o_nxt_waddr
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              w_load;

    // Ready comes straight from the valid flop, so it never depends on i_valid.
    assign o_ready = !r_valid;

    // A $zero transfer still completes the handshake, it just is not stored.
    assign w_load = i_valid && !r_valid && (i_waddr != ADDR_W'(REG_ZERO));

    assign o_valid     = r_valid;
    assign o_waddr     = r_waddr;
    assign o_wdata     = r_wdata;
    assign o_load      = w_load;
    assign o_nxt_valid = w_load || (r_valid && !i_clear);
    assign o_nxt_waddr = w_load ? i_waddr : r_waddr;

    // Load and clear are exclusive: a granted entry means the buffer was full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            if (w_load) begin
                r_valid <= 1'b1;
                r_waddr <= i_waddr;
                r_wdata <= i_wdata;
            end else if (i_clear) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rf_write_arbiter
//  Purpose  : Shares the register-file write port between the ALU and the
//             load unit. Each requester has a one-entry buffer; a round-robin
//             arbiter with same-address ordering drains them into a
//             registered write port. A pending-write mask flags every
//             register with a write still buffered or on the output stage.
//  Ports    : clk, rst_n                       - clock, async active-low reset
//             i_alu_valid/o_alu_ready/i_alu_waddr/i_alu_wdata - ALU writeback
//             i_mem_valid/o_mem_ready/i_mem_waddr/i_mem_wdata - load writeback
//             o_rf_waddr/o_rf_wdata/o_rf_wren  - register-file write port
//             o_pend_mask                      - in-flight write mask
//             o_conflict_cnt                   - only with RF_WARB_STATS_EN
//  Options  : RF_WARB_STATS_EN - adds a saturating 16-bit counter of cycles
//             in which both buffers hold a write.
//  Revision : 1.0 - initial release
// ============================================================================
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter bit MEM_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_alu_valid,
    output logic                 o_alu_ready,
    input  logic [ADDR_W-1:0]    i_alu_waddr,
    input  logic [DATA_W-1:0]    i_alu_wdata,
    input  logic                 i_mem_valid,
    output logic                 o_mem_ready,
    input  logic [ADDR_W-1:0]    i_mem_waddr,
    input  logic [DATA_W-1:0]    i_mem_wdata,
    output logic [ADDR_W-1:0]    o_rf_waddr,
    output logic [DATA_W-1:0]    o_rf_wdata,
    output logic                 o_rf_wren,
    output logic [2**ADDR_W-1:0] o_pend_mask
`ifdef RF_WARB_STATS_EN
    ,
    output logic [15:0]          o_conflict_cnt
`endif
);

    localparam int NREG = 2**ADDR_W;

    // Buffer views
    logic              w_alu_v, w_mem_v;
    logic [ADDR_W-1:0] w_alu_a, w_mem_a;
    logic [DATA_W-1:0] w_alu_d, w_mem_d;
    logic              w_alu_load, w_mem_load;
    logic              w_alu_nv, w_mem_nv;
    logic [ADDR_W-1:0] w_alu_na, w_mem_na;

    // Arbitration
    logic              w_both, w_same, w_gnt_any, w_gnt_alu, w_gnt_mem;
    req_id_t           w_gnt_id;
    logic [ADDR_W-1:0] w_gnt_a;
    logic [DATA_W-1:0] w_gnt_d;
    logic [NREG-1:0]   w_pend_nxt;

    // State
    req_id_t           r_rr;
    logic              r_mem_older;
    logic              r_wren;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic [NREG-1:0]   r_pend;

    rf_wr_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_alu_slot (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (i_alu_valid),
        .i_waddr     (i_alu_waddr),
        .i_wdata     (i_alu_wdata),
        .i_clear     (w_gnt_alu),
        .o_ready     (o_alu_ready),
        .o_valid     (w_alu_v),
        .o_waddr     (w_alu_a),
        .o_wdata     (w_alu_d),
        .o_load      (w_alu_load),
        .o_nxt_valid (w_alu_nv),
        .o_nxt_waddr (w_alu_na)
    );

    rf_wr_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem_slot (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (i_mem_valid),
        .i_waddr     (i_mem_waddr),
        .i_wdata     (i_mem_wdata),
        .i_clear     (w_gnt_mem),
        .o_ready     (o_mem_ready),
        .o_valid     (w_mem_v),
        .o_waddr     (w_mem_a),
        .o_wdata     (w_mem_d),
        .o_load      (w_mem_load),
        .o_nxt_valid (w_mem_nv),
        .o_nxt_waddr (w_mem_na)
    );

    assign w_both    = w_alu_v && w_mem_v;
    assign w_same    = w_both && (w_alu_a == w_mem_a);
    assign w_gnt_any = w_alu_v || w_mem_v;
    assign w_gnt_alu = w_gnt_any && (w_gnt_id == REQ_ALU);
    assign w_gnt_mem = w_gnt_any && (w_gnt_id == REQ_MEM);

    // Same-address pairs go oldest first so the register ends up with the
    // younger value; otherwise contested grants follow the rr pointer.
    always_comb begin
        w_gnt_id = REQ_ALU;
        if (w_same) begin
            w_gnt_id = r_mem_older ? REQ_MEM : REQ_ALU;
        end else if (w_both) begin
            w_gnt_id = r_rr;
        end else if (w_mem_v) begin
            w_gnt_id = REQ_MEM;
        end
    end

    assign w_gnt_a = (w_gnt_id == REQ_MEM) ? w_mem_a : w_alu_a;
    assign w_gnt_d = (w_gnt_id == REQ_MEM) ? w_mem_d : w_alu_d;

    // Mask is built from next-cycle contents so it is aligned with the
    // buffers and output stage it describes.
    always_comb begin
        w_pend_nxt = '0;
        if (w_alu_nv) begin
            w_pend_nxt[w_alu_na] = 1'b1;
        end
        if (w_mem_nv) begin
            w_pend_nxt[w_mem_na] = 1'b1;
        end
        if (w_gnt_any) begin
            w_pend_nxt[w_gnt_a] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr        <= MEM_FIRST ? REQ_MEM : REQ_ALU;
            r_mem_older <= 1'b0;
            r_wren      <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_pend      <= '0;
        end else begin
            // The pointer only moves on different-address contention;
            // same-address pairs are ordered by age instead.
            if (w_both && !w_same) begin
                r_rr <= (r_rr == REQ_MEM) ? REQ_ALU : REQ_MEM;
            end
            // An ALU load makes any surviving MEM entry the older one, and a
            // simultaneous load also favours MEM so the ALU value lands last.
            if (w_alu_load) begin
                r_mem_older <= 1'b1;
            end else if (w_mem_load) begin
                r_mem_older <= 1'b0;
            end
            r_wren <= w_gnt_any;
            if (w_gnt_any) begin
                r_waddr <= w_gnt_a;
                r_wdata <= w_gnt_d;
            end
            r_pend <= w_pend_nxt;
        end
    end

    assign o_rf_wren   = r_wren;
    assign o_rf_waddr  = r_waddr;
    assign o_rf_wdata  = r_wdata;
    assign o_pend_mask = r_pend;

`ifdef RF_WARB_STATS_EN
    logic [15:0] r_conflict_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflict_cnt <= '0;
        end else if (w_both && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign o_conflict_cnt = r_conflict_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rf_write_arbiter
//  Purpose  : Self-checking bench for rf_write_arbiter: directed vector table,
//             a mid-operation reset sequence and a randomized phase checked
//             against a timestamp-based behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0, mem_valid = 1'b0;
    logic [4:0]  alu_waddr = '0, mem_waddr = '0;
    logic [31:0] alu_wdata = '0, mem_wdata = '0;
    logic        alu_ready, mem_ready, rf_wren;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pend_mask;
`ifdef RF_WARB_STATS_EN
    logic [15:0] conflict_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    rf_write_arbiter #(.DATA_W(32), .ADDR_W(5), .MEM_FIRST(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_alu_valid (alu_valid),
        .o_alu_ready (alu_ready),
        .i_alu_waddr (alu_waddr),
        .i_alu_wdata (alu_wdata),
        .i_mem_valid (mem_valid),
        .o_mem_ready (mem_ready),
        .i_mem_waddr (mem_waddr),
        .i_mem_wdata (mem_wdata),
        .o_rf_waddr  (rf_waddr),
        .o_rf_wdata  (rf_wdata),
        .o_rf_wren   (rf_wren),
        .o_pend_mask (pend_mask)
`ifdef RF_WARB_STATS_EN
        ,
        .o_conflict_cnt (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        ewren;
        logic [4:0]  ewaddr;
        logic [31:0] ewdata;
        logic        eardy;
        logic        emrdy;
        logic [31:0] epend;
    } vec_t;

    localparam int NVEC = 28;
    vec_t tbl [NVEC];

    function automatic logic [31:0] B(input int n);
        return 32'(1) << n;
    endfunction

    function automatic vec_t V(input logic av, input int aa, input logic [31:0] ad,
                               input logic mv, input int ma, input logic [31:0] md,
                               input logic ew, input int ea, input logic [31:0] ed,
                               input logic ar, input logic mr, input logic [31:0] ep);
        vec_t v;
        v.av = av; v.aa = 5'(aa); v.ad = ad;
        v.mv = mv; v.ma = 5'(ma); v.md = md;
        v.ewren = ew; v.ewaddr = 5'(ea); v.ewdata = ed;
        v.eardy = ar; v.emrdy = mr; v.epend = ep;
        return v;
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        logic        v;
        logic [4:0]  a;
        logic [31:0] d;
        int          t;   // acceptance cycle, smaller = older
    } ent_t;

    ent_t        m_alu, m_mem;
    logic        m_rr_mem;
    logic        m_ov;
    logic [4:0]  m_oa;
    logic [31:0] m_od;
    int          m_cyc;

    task automatic model_reset();
        m_alu = '{1'b0, 5'd0, 32'd0, 0};
        m_mem = '{1'b0, 5'd0, 32'd0, 0};
        m_rr_mem = 1'b1;
        m_ov = 1'b0; m_oa = '0; m_od = '0;
        m_cyc = 0;
    endtask

    // One clock edge of the spec's rules, using the inputs presented before it.
    task automatic model_step();
        logic ga, gm, acc_a, acc_m;
        ga = 1'b0; gm = 1'b0;
        acc_a = alu_valid && !m_alu.v;
        acc_m = mem_valid && !m_mem.v;
        if (m_alu.v && m_mem.v) begin
            if (m_alu.a == m_mem.a) begin
                if (m_mem.t <= m_alu.t) gm = 1'b1; else ga = 1'b1;
            end else begin
                if (m_rr_mem) gm = 1'b1; else ga = 1'b1;
                m_rr_mem = !m_rr_mem;
            end
        end else if (m_alu.v) begin
            ga = 1'b1;
        end else if (m_mem.v) begin
            gm = 1'b1;
        end
        m_ov = ga || gm;
        if (ga) begin m_oa = m_alu.a; m_od = m_alu.d; m_alu.v = 1'b0; end
        if (gm) begin m_oa = m_mem.a; m_od = m_mem.d; m_mem.v = 1'b0; end
        if (acc_a && alu_waddr != 5'd0) m_alu = '{1'b1, alu_waddr, alu_wdata, m_cyc};
        if (acc_m && mem_waddr != 5'd0) m_mem = '{1'b1, mem_waddr, mem_wdata, m_cyc};
        m_cyc++;
    endtask

    function automatic logic [31:0] model_pend();
        logic [31:0] p;
        p = '0;
        for (int r = 1; r < 32; r++) begin
            if ((m_alu.v && m_alu.a == 5'(r)) || (m_mem.v && m_mem.a == 5'(r)) ||
                (m_ov && m_oa == 5'(r)))
                p = p | B(r);
        end
        return p;
    endfunction

    task automatic drive_idle();
        alu_valid = 1'b0; alu_waddr = '0; alu_wdata = '0;
        mem_valid = 1'b0; mem_waddr = '0; mem_wdata = '0;
    endtask

    initial begin
        // ALU-only, contention (two rounds), same-address, ALU-then-MEM,
        // $zero filter, and backpressure with a held ALU valid.
        tbl[0]  = V(1, 5,'h1234, 0,0,0,       0, 0,'h0,    0,1, B(5));
        tbl[1]  = V(0, 0,0,      0,0,0,       1, 5,'h1234, 1,1, B(5));
        tbl[2]  = V(0, 0,0,      0,0,0,       0, 5,'h1234, 1,1, 0);
        tbl[3]  = V(1, 3,'hA,    1,4,'hB,     0, 5,'h1234, 0,0, B(3)|B(4));
        tbl[4]  = V(0, 0,0,      0,0,0,       1, 4,'hB,    0,1, B(3)|B(4));
        tbl[5]  = V(0, 0,0,      0,0,0,       1, 3,'hA,    1,1, B(3));
        tbl[6]  = V(0, 0,0,      0,0,0,       0, 3,'hA,    1,1, 0);
        tbl[7]  = V(1, 6,'hC,    1,7,'hD,     0, 3,'hA,    0,0, B(6)|B(7));
        tbl[8]  = V(0, 0,0,      0,0,0,       1, 6,'hC,    1,0, B(6)|B(7));
        tbl[9]  = V(0, 0,0,      0,0,0,       1, 7,'hD,    1,1, B(7));
        tbl[10] = V(0, 0,0,      0,0,0,       0, 7,'hD,    1,1, 0);
        tbl[11] = V(1, 9,'h11,   1,9,'h22,    0, 7,'hD,    0,0, B(9));
        tbl[12] = V(0, 0,0,      0,0,0,       1, 9,'h22,   0,1, B(9));
        tbl[13] = V(0, 0,0,      0,0,0,       1, 9,'h11,   1,1, B(9));
        tbl[14] = V(0, 0,0,      0,0,0,       0, 9,'h11,   1,1, 0);
        tbl[15] = V(1, 9,'h33,   0,0,0,       0, 9,'h11,   0,1, B(9));
        tbl[16] = V(0, 0,0,      1,9,'h44,    1, 9,'h33,   1,0, B(9));
        tbl[17] = V(0, 0,0,      0,0,0,       1, 9,'h44,   1,1, B(9));
        tbl[18] = V(0, 0,0,      0,0,0,       0, 9,'h44,   1,1, 0);
        tbl[19] = V(0, 0,0,      1,0,'hFFFF,  0, 9,'h44,   1,1, 0);
        tbl[20] = V(0, 0,0,      0,0,0,       0, 9,'h44,   1,1, 0);
        tbl[21] = V(1,10,'h100,  0,0,0,       0, 9,'h44,   0,1, B(10));
        tbl[22] = V(1,11,'h101,  0,0,0,       1,10,'h100,  1,1, B(10));
        tbl[23] = V(1,12,'h102,  0,0,0,       0,10,'h100,  0,1, B(12));
        tbl[24] = V(1,13,'h103,  0,0,0,       1,12,'h102,  1,1, B(12));
        tbl[25] = V(1,14,'h104,  0,0,0,       0,12,'h102,  0,1, B(14));
        tbl[26] = V(1,15,'h105,  0,0,0,       1,14,'h104,  1,1, B(14));
        tbl[27] = V(0, 0,0,      0,0,0,       0,14,'h104,  1,1, 0);

        // ---------------- reset state ----------------
        drive_idle();
        #12;
        chk("reset wren",  64'(rf_wren),   64'(0));
        chk("reset waddr", 64'(rf_waddr),  64'(0));
        chk("reset wdata", 64'(rf_wdata),  64'(0));
        chk("reset pend",  64'(pend_mask), 64'(0));
        chk("reset alu_ready", 64'(alu_ready), 64'(1));
        chk("reset mem_ready", 64'(mem_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- directed table ----------------
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            alu_valid = tbl[i].av; alu_waddr = tbl[i].aa; alu_wdata = tbl[i].ad;
            mem_valid = tbl[i].mv; mem_waddr = tbl[i].ma; mem_wdata = tbl[i].md;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d wren", i),  64'(rf_wren),   64'(tbl[i].ewren));
            chk($sformatf("row%0d waddr", i), 64'(rf_waddr),  64'(tbl[i].ewaddr));
            chk($sformatf("row%0d wdata", i), 64'(rf_wdata),  64'(tbl[i].ewdata));
            chk($sformatf("row%0d alu_ready", i), 64'(alu_ready), 64'(tbl[i].eardy));
            chk($sformatf("row%0d mem_ready", i), 64'(mem_ready), 64'(tbl[i].emrdy));
            chk($sformatf("row%0d pend", i),  64'(pend_mask), 64'(tbl[i].epend));
        end

        // ---------------- reset while both buffers hold writes ----------------
        @(negedge clk);
        alu_valid = 1'b1; alu_waddr = 5'd20; alu_wdata = 32'hAAAA;
        mem_valid = 1'b1; mem_waddr = 5'd21; mem_wdata = 32'hBBBB;
        @(posedge clk);
        #1;
        chk("pre-reset pend", 64'(pend_mask), 64'(B(20) | B(21)));
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset wren",  64'(rf_wren),   64'(0));
        chk("midreset pend",  64'(pend_mask), 64'(0));
        chk("midreset alu_ready", 64'(alu_ready), 64'(1));
        chk("midreset mem_ready", 64'(mem_ready), 64'(1));
        chk("midreset waddr", 64'(rf_waddr),  64'(0));
`ifdef RF_WARB_STATS_EN
        chk("midreset conflict_cnt", 64'(conflict_cnt), 64'(0));
`endif
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("postreset%0d wren", i), 64'(rf_wren), 64'(0));
            chk($sformatf("postreset%0d pend", i), 64'(pend_mask), 64'(0));
        end

        // ---------------- randomized phase vs model ----------------
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            alu_valid = ($urandom_range(0, 9) < 6);
            mem_valid = ($urandom_range(0, 9) < 6);
            alu_waddr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
            mem_waddr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
            alu_wdata = $urandom;
            mem_wdata = $urandom;
            @(posedge clk);
            model_step();
            #1;
            chk($sformatf("rnd%0d wren", c), 64'(rf_wren), 64'(m_ov));
            if (m_ov) begin
                chk($sformatf("rnd%0d waddr", c), 64'(rf_waddr), 64'(m_oa));
                chk($sformatf("rnd%0d wdata", c), 64'(rf_wdata), 64'(m_od));
            end
            chk($sformatf("rnd%0d alu_ready", c), 64'(alu_ready), 64'(!m_alu.v));
            chk($sformatf("rnd%0d mem_ready", c), 64'(mem_ready), 64'(!m_mem.v));
            chk($sformatf("rnd%0d pend", c), 64'(pend_mask), 64'(model_pend()));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
